seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the level meter's multiplexed 7-segment driver: watches the `cathodes`/`anodes` scan bus, locks each digit once its anode dwell is stable, and decodes the glyphs back into digit codes. It presents all four digits at once as a frame, with per-digit blank, decimal-point and error flags. Used in loopback self-test and as a synthesizable checker next to `top`.

## Interface
- `STABLE_CYCLES`, 1000: cycles a scan state must hold before capture (10 µs @ 100 MHz).
- `TIMEOUT_CYCLES`, 2_000_000: cycles without any capture before `stale` asserts (20 ms).
- `clk_100MHz` in 1: system clock.
- `reset_button` in 1: synchronous, active-high reset.
- `cathodes` in 8: segment bus, active low; [0]=a … [6]=g, [7]=dp.
- `anodes` in 4: digit select, active low; [0] is the rightmost digit.
- `digit_code` out 20: four 5-bit codes, digit i at [5i+4:5i].
- `digit_dp` out 4: decimal point lit, per digit.
- `digit_blank` out 4: no segments lit, per digit.
- `seg_err` out 4: undecodable glyph, per digit.
- `frame_valid` out 1: one-cycle pulse; all frame outputs updated this cycle.
- `multi_err` out 1: more than one anode was stably active since the last frame.
- `stale` out 1: no capture for `TIMEOUT_CYCLES`.

## Operation
- Input stage: one register on `{anodes, cathodes}`. Everything below uses the registered copy.
- Scan classification:
  - Exactly one anode low: digit `idx` is active.
  - All anodes high: idle.
  - Two or more anodes low: multi.
- Stability counter `stab_cnt`:
  - Clears whenever the registered 12-bit state differs from the previous cycle.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- Capture fires only on the cycle `stab_cnt` first reaches `STABLE_CYCLES`, so at most once per dwell.
  - Active: decode `cathodes[6:0]` into `shadow_code[idx]`; store `dp`, `blank`, `err` for `idx`; set `seen[idx]`.
  - Multi: set `multi_pend`; clear `seen`, dropping the partial frame.
  - Idle: nothing happens.
- Glyph decode:
  - Hex 0–F map to codes 0x00–0x0F. Lowercase b and d are used for B and D.
  - All segments off: `blank=1`, code 0x00.
  - Any other pattern: `err=1`, code 0x1F.
- Re-capture of a digit already in `seen` overwrites its shadow entry; the latest value wins.
- Frame completion, on the cycle after `seen==4'b1111`:
  - Copy the shadow set to the outputs.
  - Pulse `frame_valid`.
  - Drive `multi_err` from `multi_pend`, then clear `multi_pend`.
  - Clear `seen` and `stale`.
- Timeout: the idle counter clears on every capture and saturates at `TIMEOUT_CYCLES`. At saturation, `stale=1` and holds until the next `frame_valid`. Frame outputs keep their last values.

## Timing
- Latency from a scan-bus change to its capture: 1 cycle (input register) plus `STABLE_CYCLES` cycles.
- `frame_valid` follows the last-digit capture by exactly 1 cycle.
- A dwell shorter than `STABLE_CYCLES` is ignored; glitches never capture.
- The anode and cathode transitions of a digit switch count as one change. The counter restarts until both are settled.
- Reset values, all outputs and state:
  - `digit_code=0`, `digit_dp=0`, `digit_blank=4'hF`, `seg_err=0`.
  - `frame_valid=0`, `multi_err=0`, `stale=0`.
  - `seen=0`, `multi_pend=0`, counters 0.
- Reset mid-frame discards all partial captures. Reset dominates a simultaneous capture or frame completion.
- A capture on the same cycle as frame completion goes into the new (cleared) `seen` set and is not lost.

## Configuration
- Macro: `SEG7_DEC_LETTERS_EN`.
- Defined: glyphs H, L, P, `-`, n, o decode to codes 0x10–0x15 with `err=0`. The setup screens show H/L.
- Undefined: those glyphs decode as errors (code 0x1F, `err=1`).
- Port widths are identical in both builds.

## Structure
- Shared package `seg7_pkg` holds:
  - Active-high 7-bit glyph constants for 0–F and the letters.
  - Code constants `CODE_BLANK=5'h00`, `CODE_ERR=5'h1F`, `CODE_H…CODE_O` (0x10–0x15).
  - The `seg_t`/`code_t` typedefs.
- Sub-module `seg7_glyph_decode` is the combinational decoder: 7 segments in; code, `blank`, `err` out.
- Counters, capture logic and frame assembly live in `seg7_scan_decoder`.

## Test plan
- Scan digits 3..0 showing "0071" (`cathodes` C0,C0,F8,F9), each dwell 2000 cycles -> one `frame_valid`, `digit_code`=0x00,0x00,0x07,0x01, `seg_err=0`, `multi_err=0`.
- 500-cycle glitch to 8'h80 inside a 2000-cycle dwell of digit 0 -> captured code is the settled glyph, never 8.
- `anodes=4'b1100` held 2000 cycles mid-frame -> no `frame_valid` from that partial frame; next full frame shows `multi_err=1`; the frame after that shows 0.
- Glyph 8'h89 (H) on digit 3 -> `SEG7_DEC_LETTERS_EN` defined: code 0x10, `seg_err[3]=0`; undefined: code 0x1F, `seg_err[3]=1`.
- Stop the scan (`anodes=4'hF`) for `TIMEOUT_CYCLES` -> `stale=1`, outputs held; resume the scan -> `stale=0` with the next `frame_valid`.
- Assert `reset_button` 1 cycle after three digits are captured -> all outputs at reset values; a full new scan is needed before `frame_valid`.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph fonts, digit codes and scan helpers shared by the
// 7-segment scan decoder and its glyph decoder.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [4:0] code_t;

  typedef enum logic [1:0] {
    SCAN_IDLE   = 2'd0,
    SCAN_ACTIVE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  typedef struct packed {
    code_t code;
    logic  dp;
    logic  blank;
    logic  err;
  } digit_t;

  localparam code_t CODE_BLANK = 5'h00;
  localparam code_t CODE_ERR   = 5'h1F;
  localparam code_t CODE_H     = 5'h10;
  localparam code_t CODE_L     = 5'h11;
  localparam code_t CODE_P     = 5'h12;
  localparam code_t CODE_DASH  = 5'h13;
  localparam code_t CODE_N     = 5'h14;
  localparam code_t CODE_O     = 5'h15;

  // Active-high segments, bit 0 = a ... bit 6 = g
  localparam seg_t GLYPH_BLANK = 7'h00;
  localparam seg_t GLYPH_0     = 7'h3F;
  localparam seg_t GLYPH_1     = 7'h06;
  localparam seg_t GLYPH_2     = 7'h5B;
  localparam seg_t GLYPH_3     = 7'h4F;
  localparam seg_t GLYPH_4     = 7'h66;
  localparam seg_t GLYPH_5     = 7'h6D;
  localparam seg_t GLYPH_6     = 7'h7D;
  localparam seg_t GLYPH_7     = 7'h07;
  localparam seg_t GLYPH_8     = 7'h7F;
  localparam seg_t GLYPH_9     = 7'h6F;
  localparam seg_t GLYPH_A     = 7'h77;
  localparam seg_t GLYPH_B     = 7'h7C;
  localparam seg_t GLYPH_C     = 7'h39;
  localparam seg_t GLYPH_D     = 7'h5E;
  localparam seg_t GLYPH_E     = 7'h79;
  localparam seg_t GLYPH_F     = 7'h71;
  localparam seg_t GLYPH_H     = 7'h76;
  localparam seg_t GLYPH_L     = 7'h38;
  localparam seg_t GLYPH_P     = 7'h73;
  localparam seg_t GLYPH_DASH  = 7'h40;
  localparam seg_t GLYPH_N     = 7'h54;
  localparam seg_t GLYPH_O     = 7'h5C;

  localparam digit_t DIGIT_RESET = '{
    code:  CODE_BLANK,
    dp:    1'b0,
    blank: 1'b1,
    err:   1'b0
  };

  function automatic scan_kind_e scan_kind(input logic [3:0] an);
    scan_kind_e k;
    unique case (an)
      4'b1110,
      4'b1101,
      4'b1011,
      4'b0111: k = SCAN_ACTIVE;
      4'b1111: k = SCAN_IDLE;
      default: k = SCAN_MULTI;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] scan_idx(input logic [3:0] an);
    logic [1:0] i;
    unique case (an)
      4'b1101: i = 2'd1;
      4'b1011: i = 2'd2;
      4'b0111: i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational 7-segment glyph to digit code.
// Letters H L P - n o decode only when SEG7_DEC_LETTERS_EN is defined.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  seg_t  seg,
  output code_t code,
  output logic  blank,
  output logic  err
);

  always_comb begin
    code  = CODE_ERR;
    blank = 1'b0;
    err   = 1'b0;
    unique case (1'b1)
      (seg == GLYPH_BLANK): begin
        code  = CODE_BLANK;
        blank = 1'b1;
      end
      (seg == GLYPH_0): code = 5'h00;
      (seg == GLYPH_1): code = 5'h01;
      (seg == GLYPH_2): code = 5'h02;
      (seg == GLYPH_3): code = 5'h03;
      (seg == GLYPH_4): code = 5'h04;
      (seg == GLYPH_5): code = 5'h05;
      (seg == GLYPH_6): code = 5'h06;
      (seg == GLYPH_7): code = 5'h07;
      (seg == GLYPH_8): code = 5'h08;
      (seg == GLYPH_9): code = 5'h09;
      (seg == GLYPH_A): code = 5'h0A;
      (seg == GLYPH_B): code = 5'h0B;
      (seg == GLYPH_C): code = 5'h0C;
      (seg == GLYPH_D): code = 5'h0D;
      (seg == GLYPH_E): code = 5'h0E;
      (seg == GLYPH_F): code = 5'h0F;
`ifdef SEG7_DEC_LETTERS_EN
      (seg == GLYPH_H):    code = CODE_H;
      (seg == GLYPH_L):    code = CODE_L;
      (seg == GLYPH_P):    code = CODE_P;
      (seg == GLYPH_DASH): code = CODE_DASH;
      (seg == GLYPH_N):    code = CODE_N;
      (seg == GLYPH_O):    code = CODE_O;
`endif
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers 4-digit frames from a multiplexed 7-seg bus.
// Build option SEG7_DEC_LETTERS_EN enables letter glyphs in the decoder.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk_100MHz,
  input  logic        reset_button,
  input  logic [7:0]  cathodes,
  input  logic [3:0]  anodes,
  output logic [19:0] digit_code,
  output logic [3:0]  digit_dp,
  output logic [3:0]  digit_blank,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        multi_err,
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] IDLE_ONE  = TW'(1);

  logic [11:0]   bus_d;
  logic [11:0]   bus_q;
  logic          chg;
  logic          cap;
  logic          cap_active;
  logic          cap_multi;
  logic          frame_done;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    seen;
  logic [3:0]    seen_nxt;
  logic          multi_pend;
  logic          pend_nxt;
  scan_kind_e    kind;
  logic [1:0]    idx;
  seg_t          seg_on;
  code_t         dec_code;
  logic          dec_blank;
  logic          dec_err;
  digit_t        dig_new;
  digit_t [3:0]  shadow;
  digit_t [3:0]  frame_q;

  assign bus_d = {anodes, cathodes};

  // Anode and cathode edges land in the same register, so a digit switch
  // is one change and the dwell restarts until both have settled.
  assign chg = (bus_d != bus_q);
  assign cap = !chg && (stab_cnt == STAB_LAST);

  assign kind       = scan_kind(bus_q[11:8]);
  assign idx        = scan_idx(bus_q[11:8]);
  assign cap_active = cap && (kind == SCAN_ACTIVE);
  assign cap_multi  = cap && (kind == SCAN_MULTI);
  assign frame_done = (seen == 4'hF);

  assign seg_on = ~bus_q[6:0];

  seg7_glyph_decode u_glyph (
    .seg   (seg_on),
    .code  (dec_code),
    .blank (dec_blank),
    .err   (dec_err)
  );

  assign dig_new = '{
    code:  dec_code,
    dp:    ~bus_q[7],
    blank: dec_blank,
    err:   dec_err
  };

  // A capture alongside frame completion joins the freshly cleared set
  always_comb begin
    seen_nxt = frame_done ? 4'h0 : seen;
    pend_nxt = frame_done ? 1'b0 : multi_pend;
    if (cap_active) begin
      seen_nxt[idx] = 1'b1;
    end
    if (cap_multi) begin
      seen_nxt = 4'h0;
      pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset_button) begin
      bus_q    <= 12'hFFF;
      stab_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      bus_q <= bus_d;
      if (chg) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + STAB_ONE;
      end
      if (cap_active || cap_multi) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IDLE_ONE;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset_button) begin
      seen        <= 4'h0;
      multi_pend  <= 1'b0;
      shadow      <= {4{DIGIT_RESET}};
      frame_q     <= {4{DIGIT_RESET}};
      frame_valid <= 1'b0;
      multi_err   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      seen        <= seen_nxt;
      multi_pend  <= pend_nxt;
      frame_valid <= frame_done;
      if (cap_active) begin
        shadow[idx] <= dig_new;
      end
      if (frame_done) begin
        frame_q   <= shadow;
        multi_err <= multi_pend;
      end
      if (frame_done) begin
        stale <= 1'b0;
      end else if (idle_cnt == IDLE_MAX) begin
        stale <= 1'b1;
      end
    end
  end

  always_comb begin
    digit_code  = '0;
    digit_dp    = '0;
    digit_blank = '0;
    seg_err     = '0;
    for (int i = 0; i < 4; i++) begin
      digit_code[5*i +: 5] = frame_q[i].code;
      digit_dp[i]          = frame_q[i].dp;
      digit_blank[i]       = frame_q[i].blank;
      seg_err[i]           = frame_q[i].err;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scan-bus stimulus with a frame-level
// reference model; honours SEG7_DEC_LETTERS_EN like the design.
module tb_seg7_scan_decoder;

  localparam int STAB = 16;
  localparam int TOUT = 300;
  localparam int DW   = 40;

  logic        clk_100MHz   = 1'b0;
  logic        reset_button = 1'b1;
  logic [7:0]  cathodes     = 8'hFF;
  logic [3:0]  anodes       = 4'hF;
  logic [19:0] digit_code;
  logic [3:0]  digit_dp;
  logic [3:0]  digit_blank;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        multi_err;
  logic        stale;

  seg7_scan_decoder #(
    .STABLE_CYCLES  (STAB),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset_button (reset_button),
    .cathodes     (cathodes),
    .anodes       (anodes),
    .digit_code   (digit_code),
    .digit_dp     (digit_dp),
    .digit_blank  (digit_blank),
    .seg_err      (seg_err),
    .frame_valid  (frame_valid),
    .multi_err    (multi_err),
    .stale        (stale)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [19:0] code;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        multi;
  } frame_t;

  localparam frame_t RESET_FRAME = '{
    code: 20'h0, dp: 4'h0, blank: 4'hF, err: 4'h0, multi: 1'b0
  };

  // Active-low cathode font: 0-F, then H L P - n o
  logic [7:0] font [22] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
    8'h89, 8'hC7, 8'h8C, 8'hBF, 8'hAB, 8'hA3
  };

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     skip     = 1'b1;
  frame_t exp_q[$];
  frame_t held     = RESET_FRAME;

  logic [4:0] m_code  [4];
  logic       m_dp    [4];
  logic       m_blank [4];
  logic       m_err   [4];
  logic [3:0] m_seen  = 4'h0;
  logic       m_pend  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_glyph(input logic [7:0] c,
                                  output logic [4:0] code,
                                  output logic dp, output logic bl,
                                  output logic er);
    int last;
    dp   = ~c[7];
    bl   = 1'b0;
    er   = 1'b1;
    code = 5'h1F;
`ifdef SEG7_DEC_LETTERS_EN
    last = 21;
`else
    last = 15;
`endif
    if (c[6:0] == 7'h7F) begin
      bl   = 1'b1;
      er   = 1'b0;
      code = 5'h00;
    end else begin
      for (int k = 0; k <= last; k++) begin
        if (font[k][6:0] == c[6:0]) begin
          code = 5'(k);
          er   = 1'b0;
        end
      end
    end
  endfunction

  function automatic void m_capture(input logic [3:0] an,
                                    input logic [7:0] cat);
    int     lows;
    int     d;
    frame_t f;
    lows = 4 - $countones(an);
    if (lows == 1) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) d = i;
      m_glyph(cat, m_code[d], m_dp[d], m_blank[d], m_err[d]);
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
        f = '0;
        for (int i = 0; i < 4; i++) begin
          f.code[5*i +: 5] = m_code[i];
          f.dp[i]          = m_dp[i];
          f.blank[i]       = m_blank[i];
          f.err[i]         = m_err[i];
        end
        f.multi = m_pend;
        exp_q.push_back(f);
        m_seen = 4'h0;
        m_pend = 1'b0;
      end
    end else if (lows > 1) begin
      m_pend = 1'b1;
      m_seen = 4'h0;
    end
  endfunction

  task automatic dwell(input logic [3:0] an, input logic [7:0] cat,
                       input int n);
    if (n > STAB + 1) m_capture(an, cat);
    anodes   = an;
    cathodes = cat;
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic scan4(input logic [7:0] c3, input logic [7:0] c2,
                       input logic [7:0] c1, input logic [7:0] c0);
    dwell(4'b0111, c3, DW);
    dwell(4'b1011, c2, DW);
    dwell(4'b1101, c1, DW);
    dwell(4'b1110, c0, DW);
  endtask

  task automatic do_reset();
    skip         = 1'b1;
    anodes       = 4'hF;
    cathodes     = 8'hFF;
    reset_button = 1'b1;
    repeat (2) @(posedge clk_100MHz);
    #1;
    m_seen       = 4'h0;
    m_pend       = 1'b0;
    exp_q.delete();
    held         = RESET_FRAME;
    reset_button = 1'b0;
    skip         = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_code"},  digit_code,  20'h0);
    check({tag, "_dp"},    digit_dp,    4'h0);
    check({tag, "_blank"}, digit_blank, 4'hF);
    check({tag, "_err"},   seg_err,     4'h0);
    check({tag, "_fv"},    frame_valid, 1'b0);
    check({tag, "_multi"}, multi_err,   1'b0);
    check({tag, "_stale"}, stale,       1'b0);
  endtask

  always @(negedge clk_100MHz) begin
    if (!skip) begin
      if (frame_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_valid: got unexpected pulse, expected none");
        end else begin
          held = exp_q.pop_front();
          check("frame_stale", stale, 1'b0);
        end
      end
      check("cyc_code",  digit_code,  held.code);
      check("cyc_dp",    digit_dp,    held.dp);
      check("cyc_blank", digit_blank, held.blank);
      check("cyc_err",   seg_err,     held.err);
      check("cyc_multi", multi_err,   held.multi);
    end
  end

  initial begin
    do_reset();
    check_reset_vals("rst0");

    scan4(8'hC0, 8'hC0, 8'hF8, 8'hF9);
    check("f0071_code",  digit_code,  20'h000E1);
    check("f0071_err",   seg_err,     4'h0);
    check("f0071_blank", digit_blank, 4'h0);
    check("f0071_multi", multi_err,   1'b0);

    scan4(8'hFE, 8'hFF, 8'h78, 8'hC0);
    check("fmix_code",  digit_code,  20'hF80E0);
    check("fmix_blank", digit_blank, 4'b0100);
    check("fmix_dp",    digit_dp,    4'b0010);
    check("fmix_err",   seg_err,     4'b1000);

    dwell(4'b0111, 8'hC0, DW);
    dwell(4'b1011, 8'hC0, DW);
    dwell(4'b1101, 8'hF8, DW);
    dwell(4'b1110, 8'hF9, 10);
    dwell(4'b1110, 8'h80, 8);
    dwell(4'b1110, 8'hF9, DW);
    check("glitch_code", digit_code, 20'h000E1);

    dwell(4'b0111, 8'hC0, DW);
    dwell(4'b1011, 8'hC0, DW);
    dwell(4'b1100, 8'hF9, DW);
    scan4(8'hC0, 8'hC0, 8'hF8, 8'hF9);
    check("multi_set", multi_err, 1'b1);
    scan4(8'hC0, 8'hC0, 8'hF8, 8'hF9);
    check("multi_clr", multi_err, 1'b0);

    scan4(8'h89, 8'hC0, 8'hF8, 8'hF9);
`ifdef SEG7_DEC_LETTERS_EN
    check("letter_code", digit_code, 20'h800E1);
    check("letter_err",  seg_err,    4'b0000);
`else
    check("letter_code", digit_code, 20'hF80E1);
    check("letter_err",  seg_err,    4'b1000);
`endif
    check("stale_pre", stale, 1'b0);

    dwell(4'hF, 8'hFF, TOUT + 60);
    check("stale_set", stale, 1'b1);
    dwell(4'b0111, 8'hC0, DW);
    check("stale_hold", stale, 1'b1);
    dwell(4'b1011, 8'hC0, DW);
    dwell(4'b1101, 8'hF8, DW);
    dwell(4'b1110, 8'hF9, DW);
    check("stale_clr", stale, 1'b0);

    dwell(4'b0111, 8'hA4, DW);
    dwell(4'b1011, 8'hB0, DW);
    dwell(4'b1101, 8'h99, DW);
    do_reset();
    check_reset_vals("rst1");
    scan4(8'hA4, 8'hB0, 8'h99, 8'h92);
    check("f2345_code", digit_code, 20'h10C85);

    check("frames_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
